// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared funct3 encodings, sequencer states and size helpers
package lsu_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic {IDLE, SECOND} lsu_state_t;

  function automatic logic [3:0] size_mask(input logic [2:0] funct3);
    case (funct3[1:0])
      2'b00:   return 4'b0001;
      2'b01:   return 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  // An access splits when its last byte lands beyond lane 3.
  function automatic logic needs_split(input logic [2:0] funct3, input logic [1:0] off);
    case (funct3[1:0])
      2'b00:   return 1'b0;
      2'b01:   return off == 2'd3;
      default: return off != 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// rtl/lsu_lane_align.sv - lane shifting, byte enables and load extension for both halves
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  off,
  input  logic        second,
  input  logic [31:0] wd,
  input  logic [31:0] rdata,
  input  logic [31:0] hold,
  output logic [3:0]  be,
  output logic [31:0] wd_lane,
  output logic [31:0] rd_ext,
  output logic        split
);

  logic [3:0]  mask;
  logic [2:0]  back;
  logic [31:0] raw;

  always_comb begin
    mask  = size_mask(funct3);
    split = needs_split(funct3, off);
    back  = 3'd4 - {1'b0, off};
    if (second) begin
      // Upper half: bytes that spilled past lane 3 come back down to lane 0.
      be      = mask >> back;
      wd_lane = wd >> {back, 3'b000};
      raw     = 32'({rdata, hold} >> {off, 3'b000});
    end else begin
      be      = mask << off;
      wd_lane = wd << {off, 3'b000};
      raw     = rdata >> {off, 3'b000};
    end
    case (funct3[1:0])
      2'b00:   rd_ext = {{24{~funct3[2] & raw[7]}}, raw[7:0]};
      2'b01:   rd_ext = {{16{~funct3[2] & raw[15]}}, raw[15:0]};
      default: rd_ext = raw;
    endcase
  end

endmodule

// File: rtl/lsu_misalign_seq.sv
// rtl/lsu_misalign_seq.sv - load/store sequencer splitting word-crossing accesses in two
module lsu_misalign_seq
  import lsu_pkg::*;
#(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  MemRead,
  input  logic                  MemWrite,
  input  logic [2:0]            Funct3,
  input  logic [DM_ADDRESS-1:0] addr,
  input  logic [DATA_W-1:0]     wd,
  output logic [DATA_W-1:0]     rd,
  output logic                  stall,
  output logic [15:0]           misalign_count,
  output logic [DM_ADDRESS-1:0] mem_addr,
  output logic [DATA_W-1:0]     mem_wd,
  output logic [3:0]            mem_be,
  output logic                  mem_we,
  output logic                  mem_re,
  input  logic [DATA_W-1:0]     mem_rdata
);

  lsu_state_t            state_q, state_d;
  logic [DATA_W-1:0]     hold_q, hold_d;
  logic [15:0]           count_q, count_d;
  logic                  wr_q, wr_d;
  logic [DM_ADDRESS-1:0] lo_addr;
  logic [3:0]            lane_be;
  logic [DATA_W-1:0]     lane_wd, lane_rd;
  logic                  split;
  logic                  is_write;

  assign lo_addr        = {addr[DM_ADDRESS-1:2], 2'b00};
  assign is_write       = MemWrite & ~MemRead;
  assign mem_wd         = lane_wd;
  assign misalign_count = count_q;

  lsu_lane_align u_align (
    .funct3  (Funct3),
    .off     (addr[1:0]),
    .second  (state_q == SECOND),
    .wd      (wd),
    .rdata   (mem_rdata),
    .hold    (hold_q),
    .be      (lane_be),
    .wd_lane (lane_wd),
    .rd_ext  (lane_rd),
    .split   (split)
  );

  always_comb begin
    state_d  = state_q;
    hold_d   = hold_q;
    count_d  = count_q;
    wr_d     = wr_q;
    mem_addr = lo_addr;
    mem_be   = 4'b0000;
    mem_we   = 1'b0;
    mem_re   = 1'b0;
    rd       = '0;
    stall    = 1'b0;
    if (!reset) begin
      case (state_q)
        IDLE: begin
          if (MemRead | MemWrite) begin
            mem_re = MemRead;
            mem_we = is_write;
            if (is_write) mem_be = lane_be;
            if (split) begin
              stall   = 1'b1;
              hold_d  = mem_rdata;
              wr_d    = is_write;
              state_d = SECOND;
              if (count_q != 16'hFFFF) count_d = count_q + 16'd1;
            end else if (MemRead) begin
              rd = lane_rd;
            end
          end
        end
        SECOND: begin
          // Direction is latched so the second half completes even if requests drop.
          mem_addr = lo_addr + DM_ADDRESS'(4);
          mem_we   = wr_q;
          mem_re   = ~wr_q;
          if (wr_q) mem_be = lane_be;
          else      rd     = lane_rd;
          state_d  = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      hold_q  <= '0;
      count_q <= 16'd0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      count_q <= count_d;
      wr_q    <= wr_d;
    end
  end

endmodule

// File: tb/tb_lsu_misalign_seq.sv
// tb/tb_lsu_misalign_seq.sv - directed vector bench for lsu_misalign_seq
module tb_lsu_misalign_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemRead, MemWrite;
  logic [2:0]  Funct3;
  logic [8:0]  addr;
  logic [31:0] wd;
  logic [31:0] rd;
  logic        stall;
  logic [15:0] misalign_count;
  logic [8:0]  mem_addr;
  logic [31:0] mem_wd;
  logic [3:0]  mem_be;
  logic        mem_we, mem_re;
  logic [31:0] mem_rdata;

  logic [31:0] mem [0:127];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lsu_misalign_seq dut (
    .clk            (clk),
    .reset          (reset),
    .MemRead        (MemRead),
    .MemWrite       (MemWrite),
    .Funct3         (Funct3),
    .addr           (addr),
    .wd             (wd),
    .rd             (rd),
    .stall          (stall),
    .misalign_count (misalign_count),
    .mem_addr       (mem_addr),
    .mem_wd         (mem_wd),
    .mem_be         (mem_be),
    .mem_we         (mem_we),
    .mem_re         (mem_re),
    .mem_rdata      (mem_rdata)
  );

  assign mem_rdata = mem[mem_addr[8:2]];

  always @(negedge clk) begin
    if (mem_we) begin
      if (mem_be[0]) mem[mem_addr[8:2]][7:0]   <= mem_wd[7:0];
      if (mem_be[1]) mem[mem_addr[8:2]][15:8]  <= mem_wd[15:8];
      if (mem_be[2]) mem[mem_addr[8:2]][23:16] <= mem_wd[23:16];
      if (mem_be[3]) mem[mem_addr[8:2]][31:24] <= mem_wd[31:24];
    end
  end

  typedef struct {
    logic        rd_en;
    logic        wr_en;
    logic [2:0]  f3;
    logic [8:0]  a;
    logic [31:0] w;
    logic [31:0] exp_rd;
    logic [3:0]  exp_be;
    logic        exp_re;
    logic        exp_we;
    logic [31:0] exp_wd;
  } vec_t;

  vec_t vecs [0:13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic w, input logic [2:0] f, input logic [8:0] a, input logic [31:0] d);
    MemRead = r; MemWrite = w; Funct3 = f; addr = a; wd = d;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] saved_w4;

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = 32'h0;
    mem[0]   = 32'h44332211;
    mem[1]   = 32'h88776655;
    mem[127] = 32'hDDCCBBAA;

    vecs[0]  = '{1, 0, 3'b010, 9'd0,  32'h0,        32'h44332211, 4'b0000, 1, 0, 32'h0};
    vecs[1]  = '{1, 0, 3'b000, 9'd7,  32'h0,        32'hFFFFFF88, 4'b0000, 1, 0, 32'h0};
    vecs[2]  = '{1, 0, 3'b100, 9'd7,  32'h0,        32'h00000088, 4'b0000, 1, 0, 32'h0};
    vecs[3]  = '{1, 0, 3'b001, 9'd2,  32'h0,        32'h00004433, 4'b0000, 1, 0, 32'h0};
    vecs[4]  = '{1, 0, 3'b101, 9'd6,  32'h0,        32'h00008877, 4'b0000, 1, 0, 32'h0};
    vecs[5]  = '{1, 0, 3'b001, 9'd6,  32'h0,        32'hFFFF8877, 4'b0000, 1, 0, 32'h0};
    vecs[6]  = '{1, 0, 3'b000, 9'd1,  32'h0,        32'h00000022, 4'b0000, 1, 0, 32'h0};
    vecs[7]  = '{0, 0, 3'b010, 9'd0,  32'h0,        32'h00000000, 4'b0000, 0, 0, 32'h0};
    vecs[8]  = '{1, 1, 3'b000, 9'd0,  32'hFFFFFFFF, 32'h00000011, 4'b0000, 1, 0, 32'h0};
    vecs[9]  = '{0, 1, 3'b000, 9'd9,  32'h1234565A, 32'h00000000, 4'b0010, 0, 1, 32'h34565A00};
    vecs[10] = '{1, 0, 3'b010, 9'd8,  32'h0,        32'h00005A00, 4'b0000, 1, 0, 32'h0};
    vecs[11] = '{0, 1, 3'b001, 9'd10, 32'h0000C0DE, 32'h00000000, 4'b1100, 0, 1, 32'hC0DE0000};
    vecs[12] = '{1, 0, 3'b010, 9'd8,  32'h0,        32'hC0DE5A00, 4'b0000, 1, 0, 32'h0};
    vecs[13] = '{1, 0, 3'b000, 9'd11, 32'h0,        32'hFFFFFFC0, 4'b0000, 1, 0, 32'h0};

    reset = 1'b1;
    drive(1, 0, 3'b010, 9'd0, 32'h0);
    #2;
    chk("reset_stall", {31'b0, stall}, 32'h0);
    chk("reset_re", {31'b0, mem_re}, 32'h0);
    chk("reset_rd", rd, 32'h0);
    next_cycle();
    next_cycle();
    reset = 1'b0;
    drive(0, 0, 3'b000, 9'd0, 32'h0);
    #3;
    chk("reset_count", {16'b0, misalign_count}, 32'h0);
    next_cycle();

    for (int i = 0; i < 14; i++) begin
      drive(vecs[i].rd_en, vecs[i].wr_en, vecs[i].f3, vecs[i].a, vecs[i].w);
      #3;
      chk($sformatf("v%0d_rd", i), rd, vecs[i].exp_rd);
      chk($sformatf("v%0d_stall", i), {31'b0, stall}, 32'h0);
      chk($sformatf("v%0d_be", i), {28'b0, mem_be}, {28'b0, vecs[i].exp_be});
      chk($sformatf("v%0d_re", i), {31'b0, mem_re}, {31'b0, vecs[i].exp_re});
      chk($sformatf("v%0d_we", i), {31'b0, mem_we}, {31'b0, vecs[i].exp_we});
      if (vecs[i].exp_we) chk($sformatf("v%0d_wd", i), mem_wd, vecs[i].exp_wd);
      next_cycle();
    end
    drive(0, 0, 3'b000, 9'd0, 32'h0);
    #3;
    chk("table_count", {16'b0, misalign_count}, 32'h0);
    next_cycle();

    // split LW at offset 2
    drive(1, 0, 3'b010, 9'd2, 32'h0);
    #3;
    chk("lw2_c1_stall", {31'b0, stall}, 32'h1);
    chk("lw2_c1_addr", {23'b0, mem_addr}, 32'h0);
    next_cycle();
    #3;
    chk("lw2_c2_addr", {23'b0, mem_addr}, 32'h4);
    chk("lw2_c2_stall", {31'b0, stall}, 32'h0);
    chk("lw2_c2_rd", rd, 32'h66554433);
    chk("lw2_count", {16'b0, misalign_count}, 32'h1);
    next_cycle();

    // split SH at offset 3
    drive(0, 1, 3'b001, 9'd3, 32'h0000BEEF);
    #3;
    chk("sh3_c1_be", {28'b0, mem_be}, 32'h8);
    chk("sh3_c1_wd", {24'b0, mem_wd[31:24]}, 32'hEF);
    chk("sh3_c1_stall", {31'b0, stall}, 32'h1);
    next_cycle();
    #3;
    chk("sh3_c2_addr", {23'b0, mem_addr}, 32'h4);
    chk("sh3_c2_be", {28'b0, mem_be}, 32'h1);
    chk("sh3_c2_wd", {24'b0, mem_wd[7:0]}, 32'hBE);
    chk("sh3_c2_we", {31'b0, mem_we}, 32'h1);
    next_cycle();
    drive(1, 0, 3'b010, 9'd0, 32'h0);
    #3;
    chk("sh3_word0", rd, 32'hEF332211);
    chk("sh3_count", {16'b0, misalign_count}, 32'h2);
    next_cycle();
    drive(1, 0, 3'b010, 9'd4, 32'h0);
    #3;
    chk("sh3_word4", rd, 32'h887766BE);
    next_cycle();

    // split LW wrapping past the top of memory
    drive(1, 0, 3'b010, 9'h1FE, 32'h0);
    #3;
    chk("wrap_c1_addr", {23'b0, mem_addr}, 32'h1FC);
    chk("wrap_c1_stall", {31'b0, stall}, 32'h1);
    next_cycle();
    #3;
    chk("wrap_c2_addr", {23'b0, mem_addr}, 32'h0);
    chk("wrap_c2_rd", rd, 32'h2211DDCC);
    chk("wrap_count", {16'b0, misalign_count}, 32'h3);
    next_cycle();

    // split SW aborted by reset in the second cycle
    saved_w4 = mem[1];
    drive(0, 1, 3'b010, 9'd1, 32'hCAFEBABE);
    #3;
    chk("abort_c1_stall", {31'b0, stall}, 32'h1);
    chk("abort_c1_be", {28'b0, mem_be}, 32'hE);
    chk("abort_c1_we", {31'b0, mem_we}, 32'h1);
    next_cycle();
    reset = 1'b1;
    #3;
    chk("abort_c2_stall", {31'b0, stall}, 32'h0);
    chk("abort_c2_we", {31'b0, mem_we}, 32'h0);
    chk("abort_c2_be", {28'b0, mem_be}, 32'h0);
    next_cycle();
    reset = 1'b0;
    drive(0, 0, 3'b000, 9'd0, 32'h0);
    #3;
    chk("abort_count", {16'b0, misalign_count}, 32'h0);
    next_cycle();
    drive(1, 0, 3'b010, 9'd4, 32'h0);
    #3;
    chk("abort_word4", rd, saved_w4);
    chk("abort_idle_stall", {31'b0, stall}, 32'h0);
    next_cycle();
    drive(1, 0, 3'b010, 9'd0, 32'h0);
    #3;
    chk("abort_word0", rd, 32'hFEBABE11);
    next_cycle();
    drive(0, 0, 3'b000, 9'd0, 32'h0);
    next_cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
